// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: round-robin arbiter letting two masters share one byte-addressed data memory.
// One transaction in flight: IDLE grants, ACCESS drives the memory, RESP returns data/err to the winner.
module dmem_arbiter #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  input  logic [1:0]        m0_size,
  input  logic              m0_uns,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  input  logic [1:0]        m1_size,
  input  logic              m1_uns,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              m1_err,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_wen,
  output logic [3:0]        mem_wmask,
  input  logic [DWIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_port;
  logic              r_we;
  logic              r_uns;
  logic [1:0]        r_size;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_wen;
  logic [3:0]        r_wmask;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              r_err0;
  logic              r_err1;
  logic [DWIDTH-1:0] r_rdata0;
  logic [DWIDTH-1:0] r_rdata1;

  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_sel_we;
  logic              w_sel_uns;
  logic [1:0]        w_sel_size;
  logic [AWIDTH-1:0] w_sel_addr;
  logic [DWIDTH-1:0] w_sel_wdata;
  logic [3:0]        w_sel_mask;
  logic              w_illegal;
  logic [DWIDTH-1:0] w_ext;
  logic              w_fire;
  logic              w_rport;
  logic              w_rerr;
  logic [DWIDTH-1:0] w_rdat;

  // Gated by rst so no grant can leak out while the FSM is being held in reset.
  assign w_idle = (r_state == IDLE) && !rst;
  assign w_gnt0 = w_idle && m0_req && (!m1_req || r_last_grant);
  assign w_gnt1 = w_idle && m1_req && (!m0_req || !r_last_grant);
  assign w_any  = w_gnt0 || w_gnt1;

  assign w_sel_we    = w_gnt1 ? m1_we    : m0_we;
  assign w_sel_uns   = w_gnt1 ? m1_uns   : m0_uns;
  assign w_sel_size  = w_gnt1 ? m1_size  : m0_size;
  assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;

  always_comb begin
    w_illegal  = 1'b0;
    w_sel_mask = 4'b0000;
    case (w_sel_size)
      2'b00: w_sel_mask = 4'b0001;
      2'b01: begin
        w_sel_mask = 4'b0011;
        w_illegal  = w_sel_addr[0];
      end
      2'b10: begin
        w_sel_mask = 4'b1111;
        w_illegal  = (w_sel_addr[1:0] != 2'b00);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_ext = mem_rdata;
    case (r_size)
      2'b00:   w_ext = {{(DWIDTH-8){~r_uns & mem_rdata[7]}}, mem_rdata[7:0]};
      2'b01:   w_ext = {{(DWIDTH-16){~r_uns & mem_rdata[15]}}, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // A response is launched either at the end of ACCESS or straight from IDLE for an illegal request.
  assign w_fire  = (r_state == ACCESS) || (w_any && w_illegal);
  assign w_rport = (r_state == ACCESS) ? r_port : w_gnt1;
  assign w_rerr  = (r_state != ACCESS);
  assign w_rdat  = ((r_state == ACCESS) && !r_we) ? w_ext : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wen        <= 1'b0;
      r_wmask      <= 4'b0000;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_wen     <= 1'b0;
      r_wmask   <= 4'b0000;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last_grant <= w_gnt1;
            r_port       <= w_gnt1;
            r_we         <= w_sel_we;
            r_uns        <= w_sel_uns;
            r_size       <= w_sel_size;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            if (w_illegal) begin
              r_state <= RESP;
            end else begin
              r_state <= ACCESS;
              r_wen   <= w_sel_we;
              r_wmask <= w_sel_we ? w_sel_mask : 4'b0000;
            end
          end
        end
        ACCESS:  r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_fire) begin
        r_rvalid0 <= !w_rport;
        r_rvalid1 <= w_rport;
        r_err0    <= !w_rport && w_rerr;
        r_err1    <= w_rport && w_rerr;
        r_rdata0  <= w_rport ? '0 : w_rdat;
        r_rdata1  <= w_rport ? w_rdat : '0;
      end
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_err    = r_err0;
  assign m1_err    = r_err1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wen   = r_wen;
  assign mem_wmask = r_wmask;
endmodule
